// File: rtl/fft_iter_core.sv
// fft_iter_core
// Frame-based radix-2 decimation-in-time FFT/IFFT engine. One butterfly is
// time-shared over an in-place register-array buffer, so a frame takes
// N (load) + (N/2)*log2(N) (compute) + N (unload) cycles at minimum.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input sample stream, natural order (in_re, in_im)
//   in_inv                0 = forward, 1 = inverse; taken with sample 0
//   out_valid/out_ready   output bin stream, natural order (out_re, out_im)
//   out_index, out_last   bin number of the current output, high on bin N-1
//   busy                  high while computing or unloading
//   dbg_state             current FSM state (0 LOAD, 1 COMPUTE, 2 UNLOAD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds data stable while valid is high and ready is
// low; ready never depends on the valid of the same interface.
module fft_iter_core #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic [$clog2(N)-1:0]  out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  localparam int  LOGN = $clog2(N);
  localparam int  SW   = $clog2(LOGN);
  localparam int  BW   = LOGN - 1;
  localparam int  DW1  = DATA_WIDTH + 1;
  localparam int  PW   = DATA_WIDTH + TW_WIDTH + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_WIDTH - 2);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_UNLOAD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] load_cnt_q, load_cnt_d;
  logic [LOGN-1:0] out_idx_q, out_idx_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [BW-1:0]   bfly_q, bfly_d;
  logic            inv_q, inv_d;
  logic            in_hs;

  logic [DATA_WIDTH-1:0] mem_re_q [N];
  logic [DATA_WIDTH-1:0] mem_im_q [N];

  // Constant twiddle tables; the argument is always a genvar so these fold
  // to constants. +1.0 maps to 2^(TW_WIDTH-1)-1.
  function automatic logic [TW_WIDTH-1:0] tw_val(input int t, input bit use_sin);
    real ang, v, scale;
    ang   = 2.0 * PI * real'(t) / real'(N);
    scale = real'((1 << (TW_WIDTH - 1)) - 1);
    v     = use_sin ? $sin(ang) : $cos(ang);
    v     = v * scale;
    return TW_WIDTH'($rtoi((v >= 0.0) ? v + 0.5 : v - 0.5));
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  logic [TW_WIDTH-1:0] tw_cos_w [N/2];
  logic [TW_WIDTH-1:0] tw_sin_w [N/2];
  for (genvar g = 0; g < N / 2; g++) begin : g_tw
    assign tw_cos_w[g] = tw_val(g, 1'b0);
    assign tw_sin_w[g] = tw_val(g, 1'b1);
  end

  // FSM: next state, counters and handshake outputs.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    out_idx_d  = out_idx_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    inv_d      = inv_q;
    in_ready   = 1'b0;
    in_hs      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_LOAD: begin
        // Held low during reset so nothing is accepted while rst is high.
        in_ready = !rst;
        in_hs    = in_valid && !rst;
        if (in_hs) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == '0) inv_d = in_inv;
          if (load_cnt_q == LOGN'(N - 1)) begin
            state_d = S_COMPUTE;
            stage_d = '0;
            bfly_d  = '0;
          end
        end
      end
      S_COMPUTE: begin
        busy   = 1'b1;
        bfly_d = bfly_q + 1'b1;
        if (bfly_q == BW'(N / 2 - 1)) begin
          bfly_d = '0;
          if (stage_q == SW'(LOGN - 1)) state_d = S_UNLOAD;
          else stage_d = stage_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          out_idx_d = out_idx_q + 1'b1;  // wraps to 0 after bin N-1
          if (out_idx_q == LOGN'(N - 1)) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      out_idx_q  <= '0;
      stage_q    <= '0;
      bfly_q     <= '0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      out_idx_q  <= out_idx_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      inv_q      <= inv_d;
    end
  end

  // Butterfly addressing and arithmetic.
  logic [LOGN-1:0]             k_ext, h_bit, j_idx, a_idx, b_idx;
  logic [LOGN-2:0]             tw_idx;
  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_WIDTH-1:0]  w_re, w_im, sin_v;
  logic signed [PW-1:0]        p_re, p_im, p_rnd_re, p_rnd_im;
  logic signed [DW1-1:0]       pr_re, pr_im, s_re, s_im, d_re, d_im;
  logic [DATA_WIDTH-1:0]       a_new_re, a_new_im, b_new_re, b_new_im;

  always_comb begin
    k_ext = LOGN'(bfly_q);
    h_bit = LOGN'(1) << stage_q;
    j_idx = k_ext & (h_bit - 1'b1);
    // a = (k/h)*2h + j: insert a zero bit at position s of k.
    a_idx = (((k_ext >> stage_q) << 1) << stage_q) | j_idx;
    b_idx = a_idx | h_bit;
    // t = j*N/(2h) = j << (log2(N)-1-s); always below N/2.
    tw_idx = (LOGN-1)'(j_idx << (LOGN - 1 - int'(stage_q)));

    a_re  = $signed(mem_re_q[a_idx]);
    a_im  = $signed(mem_im_q[a_idx]);
    b_re  = $signed(mem_re_q[b_idx]);
    b_im  = $signed(mem_im_q[b_idx]);
    w_re  = $signed(tw_cos_w[tw_idx]);
    sin_v = $signed(tw_sin_w[tw_idx]);
    // Forward uses exp(-j*theta); inverse uses the conjugate.
    w_im  = inv_q ? sin_v : -sin_v;

    p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    p_rnd_re = p_re + RND;
    p_rnd_im = p_im + RND;
    pr_re = DW1'(p_rnd_re >>> (TW_WIDTH - 1));
    pr_im = DW1'(p_rnd_im >>> (TW_WIDTH - 1));

    // Halving every stage gives 1/N overall and keeps results in range.
    s_re = DW1'(a_re) + pr_re;
    s_im = DW1'(a_im) + pr_im;
    d_re = DW1'(a_re) - pr_re;
    d_im = DW1'(a_im) - pr_im;
    a_new_re = DATA_WIDTH'(s_re >>> 1);
    a_new_im = DATA_WIDTH'(s_im >>> 1);
    b_new_re = DATA_WIDTH'(d_re >>> 1);
    b_new_im = DATA_WIDTH'(d_im >>> 1);
  end

  // Buffer is not reset; its contents are meaningless outside a frame.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_re_q[bitrev(load_cnt_q)] <= in_re;
      mem_im_q[bitrev(load_cnt_q)] <= in_im;
    end else if (state_q == S_COMPUTE) begin
      mem_re_q[a_idx] <= a_new_re;
      mem_im_q[a_idx] <= a_new_im;
      mem_re_q[b_idx] <= b_new_re;
      mem_im_q[b_idx] <= b_new_im;
    end
  end

  assign out_re    = mem_re_q[out_idx_q];
  assign out_im    = mem_im_q[out_idx_q];
  assign out_index = out_idx_q;
  assign out_last  = (state_q == S_UNLOAD) && (out_idx_q == LOGN'(N - 1));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core (N=16): impulse, DC, tone with latency,
// inverse, backpressure with in_valid held high, and reset mid-frame.
module tb_fft_iter_core;
  localparam int  N  = 16;
  localparam int  DW = 16;
  localparam int  EW = 80;  // {tol[7:0], idx[7:0], re*256[31:0], im*256[31:0]}
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, in_inv;
  logic [DW-1:0] in_re, in_im;
  logic          out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_re, out_im;
  logic [3:0]    out_index;
  logic [1:0]    dbg_state;

  fft_iter_core #(.N(N), .DATA_WIDTH(DW), .TW_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int first_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] fr_re[N];
  logic [DW-1:0] fr_im[N];

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic push_exp(input int idx, input real re, input real im, input int tol);
    exp_q.push_back({8'(tol), 8'(idx), 32'(rnd(re * 256.0)), 32'(rnd(im * 256.0))});
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the last handshake.
  task automatic drive_frame(input logic inv, input bit hold);
    for (int i = 0; i < N; i++) begin
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_re    = fr_re[i];
      in_im    = fr_im[i];
      in_inv   = (i == 0) ? inv : 1'($urandom_range(0, 1));
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if (in_ready === 1'b1) got = 1'b1;
      end
      checks++;
      assert (got === 1'b1) else begin
        failures++;
        $error("FAIL in_handshake_timeout sample=%0d got=0 exp=1", i);
        in_valid = 1'b0;
        return;
      end
      if (i == N - 1) last_hs_cyc = cyc;
      @(posedge clk); #1;
    end
    if (hold) begin
      in_re  = 16'($urandom);
      in_im  = 16'($urandom);
      in_inv = 1'($urandom_range(0, 1));
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit bp);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
      out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
    out_ready = 1'b1;
    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL drain_timeout got=%0d exp=0 bins outstanding", exp_q.size());
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic          stall_prev = 1'b0;
  logic          after_last = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] hold_re, hold_im;
  logic [3:0]    hold_idx;
  logic          hold_last;
  logic [EW-1:0] e;
  logic [7:0]    e_idx;
  int            e_tol, e_re, e_im, g_re, g_im, d_re, d_im;
  logic          ok_re, ok_im;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      after_last = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        checks++;
        assert (in_ready === 1'b0) else begin
          failures++;
          $error("FAIL in_ready_while_busy got=%0b exp=0", in_ready);
        end
      end
      if (after_last) begin
        checks++;
        assert ({in_ready, out_valid} === 2'b10) else begin
          failures++;
          $error("FAIL after_last_ready_valid got=%b exp=10", {in_ready, out_valid});
        end
        after_last = 1'b0;
      end
      if (stall_prev) begin
        checks++;
        assert ({out_valid, out_re, out_im, out_index, out_last} ===
                {1'b1, hold_re, hold_im, hold_idx, hold_last}) else begin
          failures++;
          $error("FAIL stall_stable got=%0b/%0d/%0d/%0d exp=1/%0d/%0d/%0d",
                 out_valid, out_index, $signed(out_re), $signed(out_im),
                 hold_idx, $signed(hold_re), $signed(hold_im));
        end
      end
      if (out_valid === 1'b1 && !prev_valid) first_valid_cyc = cyc;
      prev_valid = (out_valid === 1'b1);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_output got=bin%0d exp=none", out_index);
        end
        if (exp_q.size() != 0) begin
          e     = exp_q.pop_front();
          e_tol = int'(e[79:72]);
          e_idx = e[71:64];
          e_re  = int'($signed(e[63:32]));
          e_im  = int'($signed(e[31:0]));
          g_re  = int'($signed(out_re));
          g_im  = int'($signed(out_im));
          d_re  = g_re * 256 - e_re;
          d_im  = g_im * 256 - e_im;
          if (d_re < 0) d_re = -d_re;
          if (d_im < 0) d_im = -d_im;
          ok_re = !$isunknown(out_re) && (d_re <= e_tol * 256);
          ok_im = !$isunknown(out_im) && (d_im <= e_tol * 256);
          checks++;
          assert (out_index === e_idx[3:0]) else begin
            failures++;
            $error("FAIL out_index got=%0d exp=%0d", out_index, e_idx);
          end
          checks++;
          assert (out_last === (e_idx == 8'd15)) else begin
            failures++;
            $error("FAIL out_last bin%0d got=%0b exp=%0b", e_idx, out_last, (e_idx == 8'd15));
          end
          checks++;
          assert (ok_re === 1'b1) else begin
            failures++;
            $error("FAIL bin%0d_re got=%0d exp=%0.2f tol=%0d", e_idx, g_re, real'(e_re) / 256.0, e_tol);
          end
          checks++;
          assert (ok_im === 1'b1) else begin
            failures++;
            $error("FAIL bin%0d_im got=%0d exp=%0.2f tol=%0d", e_idx, g_im, real'(e_im) / 256.0, e_tol);
          end
        end
        if (out_last === 1'b1) after_last = 1'b1;
      end
      stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
      hold_re    = out_re;
      hold_im    = out_im;
      hold_idx   = out_index;
      hold_last  = out_last;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_index", out_index, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Impulse: every bin 62+0i
    clear_frame();
    fr_re[0] = 16'd1000;
    for (int k = 0; k < N; k++) push_exp(k, 62.0, 0.0, 0);
    drive_frame(1'b0, 1'b0);
    wait_drain(1'b0);

    // Tone with latency check
    clear_frame();
    for (int n = 0; n < N; n++) fr_re[n] = 16'(rnd(8000.0 * $cos(2.0 * PI * n / 16.0)));
    for (int k = 0; k < N; k++) push_exp(k, (k == 1 || k == 15) ? 4000.0 : 0.0, 0.0, 2);
    drive_frame(1'b0, 1'b0);
    wait_drain(1'b0);
    lat = first_valid_cyc - last_hs_cyc;
    chk("tone_latency", lat, 33);

    // Inverse: X[k] = 100*exp(+j*2*pi*k/16)
    clear_frame();
    fr_re[1] = 16'd1600;
    for (int k = 0; k < N; k++)
      push_exp(k, 100.0 * $cos(2.0 * PI * k / 16.0), 100.0 * $sin(2.0 * PI * k / 16.0), 2);
    drive_frame(1'b1, 1'b0);
    wait_drain(1'b0);

    // Forward again, backpressure, in_valid held high with junk data
    for (int k = 0; k < N; k++)
      push_exp(k, 100.0 * $cos(2.0 * PI * k / 16.0), -100.0 * $sin(2.0 * PI * k / 16.0), 2);
    drive_frame(1'b0, 1'b1);
    wait_drain(1'b1);

    // DC, first sample taken right after the last output handshake
    clear_frame();
    for (int n = 0; n < N; n++) fr_re[n] = 16'd1000;
    for (int k = 0; k < N; k++) push_exp(k, (k == 0) ? 1000.0 : 0.0, 0.0, 0);
    drive_frame(1'b0, 1'b0);
    wait_drain(1'b0);

    // Reset pulse during COMPUTE aborts the frame
    clear_frame();
    fr_re[0] = 16'd1000;
    drive_frame(1'b0, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Fresh impulse after the abort
    for (int k = 0; k < N; k++) push_exp(k, 62.0, 0.0, 0);
    drive_frame(1'b0, 1'b0);
    wait_drain(1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
